// File: rtl/complement_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : complement_pkg
//  Description : Shared types and constants for the complement-code to
//                sign-magnitude decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package complement_pkg;

    // Decoder control states; width fixed at two bits.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Narrowest word that still has a sign bit and one magnitude bit.
    localparam int c_min_width = 2;

endpackage : complement_pkg
`default_nettype wire

// File: rtl/complement_lane.sv
`default_nettype none
// ============================================================================
//  Module      : complement_lane
//  Description : One bit-serial lane. Walks the magnitude bits LSB first,
//                copying up to the first 1 of a negative word and inverting
//                everything after it, then latches the sign-magnitude word.
//  Revision    : 1.0 - initial release
// ============================================================================
module complement_lane
    import complement_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_last,
    input  logic [WIDTH-1:0] i_word,
    output logic [WIDTH-1:0] o_word,
    output logic             o_ovf
);

    logic [WIDTH-2:0] r_mag;
    logic [WIDTH-2:0] r_res;
    logic             r_sign;
    logic             r_seen;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;

    logic             w_in_bit;
    logic             w_out_bit;
    logic             w_seen_next;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-2:0] w_res_next;

    // Per-bit conversion: invert only after the first 1 of a negative word.
    always_comb begin
        w_in_bit    = r_mag[0];
        w_out_bit   = (r_sign && r_seen) ? ~w_in_bit : w_in_bit;
        w_seen_next = r_seen | w_in_bit;
        // Result bits enter at the top and move down, so after the last
        // shift bit 0 of the input sits at bit 0 of the result.
        w_shifted   = {w_out_bit, r_res} >> 1;
        w_res_next  = w_shifted[WIDTH-2:0];
    end

    // Lane state: load on accept, advance on shift, latch result on last bit.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_mag  <= '0;
            r_res  <= '0;
            r_sign <= 1'b0;
            r_seen <= 1'b0;
            r_out  <= '0;
            r_ovf  <= 1'b0;
        end else if (i_load) begin
            r_mag  <= i_word[WIDTH-2:0];
            r_sign <= i_word[WIDTH-1];
            r_res  <= '0;
            r_seen <= 1'b0;
        end else if (i_shift) begin
            r_mag  <= r_mag >> 1;
            r_res  <= w_res_next;
            r_seen <= w_seen_next;
            if (i_last) begin
                r_out <= {r_sign, w_res_next};
                // Negative with an all-zero magnitude is -2^(WIDTH-1).
                r_ovf <= r_sign & ~w_seen_next;
            end
        end
    end

    assign o_word = r_out;
    assign o_ovf  = r_ovf;

endmodule : complement_lane
`default_nettype wire

// File: rtl/complement_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : complement_decoder
//  Description : Two-lane bit-serial two's-complement to sign-magnitude
//                converter with valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module complement_decoder
    import complement_pkg::*;
#(
    parameter int bitNumber = 8
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bitNumber-1:0] A,
    input  logic [bitNumber-1:0] B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bitNumber-1:0] Aout,
    output logic [bitNumber-1:0] Bout,
    output logic                 Aovf,
    output logic                 Bovf
);

    localparam int             c_cnt_w = $clog2(bitNumber);
    localparam [c_cnt_w-1:0]   c_last  = c_cnt_w'(bitNumber - 2);

    generate
        if (bitNumber < c_min_width) begin : g_param_check
            $error("complement_decoder: bitNumber must be at least 2");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_shift;
    logic               w_last;
    logic               w_handshake;

    assign in_ready    = (r_state == IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_shift     = (r_state == SHIFT);
    assign w_last      = w_shift && (r_cnt == c_last);
    assign w_handshake = r_out_valid && out_ready;

    // State register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: accept in IDLE, shift until the last magnitude bit, hold in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_next = SHIFT;
            SHIFT:   if (w_last)      w_state_next = DONE;
            DONE:    if (w_handshake) w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    // Bit counter and output-valid flag; valid rises with the last shift.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_shift && !w_last) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_last) begin
                r_out_valid <= 1'b1;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;

    complement_lane #(.WIDTH(bitNumber)) u_lane_a (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_last  (w_last),
        .i_word  (A),
        .o_word  (Aout),
        .o_ovf   (Aovf)
    );

    complement_lane #(.WIDTH(bitNumber)) u_lane_b (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_last  (w_last),
        .i_word  (B),
        .o_word  (Bout),
        .o_ovf   (Bovf)
    );

endmodule : complement_decoder
`default_nettype wire
